// File: rtl/cluster_event_bus_sink.sv
// Cluster-side sink of the SoC event bus: token synchroniser, Johnson-step capture, FWFT FIFO.
// Optional statistics outputs (push count, level high-water mark) under `EVENT_SINK_STATS_EN.
`timescale 1ns/1ps
module cluster_event_bus_sink #(
    parameter int unsigned BUFFER_WIDTH = 8,
    parameter int unsigned EVNT_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [BUFFER_WIDTH-1:0]    events_wt_i,
    input  logic [EVNT_WIDTH-1:0]      events_da_i,
    output logic [BUFFER_WIDTH-1:0]    events_rp_o,
    output logic                       evt_valid_o,
    output logic [EVNT_WIDTH-1:0]      evt_data_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
    output logic                       proto_err_o
`ifdef EVENT_SINK_STATS_EN
    ,
    output logic [31:0]                evt_count_o,
    output logic [$clog2(DEPTH+1)-1:0] max_level_o
`endif
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    function automatic logic [BUFFER_WIDTH-1:0] johnson_next(input logic [BUFFER_WIDTH-1:0] s);
        return {s[BUFFER_WIDTH-2:0], ~s[BUFFER_WIDTH-1]};
    endfunction

    // Legal Johnson states are a single run of ones touching bit 0 or the MSB.
    function automatic logic johnson_legal(input logic [BUFFER_WIDTH-1:0] s);
        logic [BUFFER_WIDTH-1:0] inv;
        inv = ~s;
        return ((s & (s + BUFFER_WIDTH'(1))) == '0) || ((inv & (inv + BUFFER_WIDTH'(1))) == '0);
    endfunction

    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] wt_s;

    logic [BUFFER_WIDTH-1:0] rp_q, rp_d;
    logic                    err_q, err_d;

    logic [EVNT_WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           count_q, count_d;
    logic                    full_q;

    logic pending, step_ok, push, pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= events_wt_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wt_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        pending = (wt_s != rp_q);
        step_ok = (wt_s == johnson_next(rp_q));
        push    = 1'b0;
        rp_d    = rp_q;
        err_d   = err_q;
        if (pending) begin
            if (step_ok) begin
                if (!full_q) begin
                    push = 1'b1;
                    rp_d = wt_s;
                end
            end else begin
                err_d = 1'b1;
                if (johnson_legal(wt_s)) begin
                    rp_d = wt_s;
                end
            end
        end
    end

    always_comb begin
        pop      = (count_q != '0) && evt_ready_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rp_q     <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rp_q     <= rp_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == LW'(DEPTH));
            if (push) begin
                mem_q[wr_ptr_q] <= events_da_i;
            end
        end
    end

    assign events_rp_o  = rp_q;
    assign proto_err_o  = err_q;
    assign fifo_level_o = count_q;
    assign evt_valid_o  = (count_q != '0);
    assign evt_data_o   = mem_q[rd_ptr_q];

`ifdef EVENT_SINK_STATS_EN
    logic [31:0]   evt_count_q;
    logic [LW-1:0] max_level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_count_q <= '0;
            max_level_q <= '0;
        end else begin
            if (push) begin
                evt_count_q <= evt_count_q + 32'd1;
            end
            if (count_d > max_level_q) begin
                max_level_q <= count_d;
            end
        end
    end

    assign evt_count_o = evt_count_q;
    assign max_level_o = max_level_q;
`endif

endmodule
